apb_ahb_bridge: RTL and testbench

- APB3 slave to AHB-lite master bridge; single clock domain.
- Lets an APB-side initiator (debug/config agent on the peripheral bus) issue single-word reads/writes into the AHB system.
- Each APB access becomes exactly one AHB SINGLE NONSEQ word transfer. PREADY is held low until the AHB data phase completes.

---
 rtl/apb_ahb_bridge_pkg.sv | 16 +
 rtl/apb_ahb_bridge.sv | 96 +++++++++
 tb/tb_apb_ahb_bridge.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_ahb_bridge_pkg.sv
// Shared AHB/APB encodings and bridge FSM states.
// Imported by the APB-to-AHB bridge.
package apb_ahb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/apb_ahb_bridge.sv
// APB3 slave to AHB-lite master bridge.
// One APB access becomes one SINGLE NONSEQ word transfer.
module apb_ahb_bridge
  import apb_ahb_bridge_pkg::*;
#(
  parameter int          PADDR_WIDTH = 16,
  parameter logic [31:0] AHB_BASE    = 32'h4000_0000,
  parameter logic [3:0]  HPROT_VAL   = 4'b0011
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [PADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]            PWDATA,
  output logic [31:0]            PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic [31:0]            HADDR,
  output logic [1:0]             HTRANS,
  output logic [2:0]             HSIZE,
  output logic [2:0]             HBURST,
  output logic [3:0]             HPROT,
  output logic                   HMASTLOCK,
  output logic                   HWRITE,
  output logic [31:0]            HWDATA,
  input  logic [31:0]            HRDATA,
  input  logic                   HREADY,
  input  logic                   HRESP
);

  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [PADDR_WIDTH-3:0] addr_q;
  logic                   write_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic                   err_q;
  logic                   setup;
  logic                   unused_lsb;

  assign setup      = PSEL & ~PENABLE;
  assign unused_lsb = ^PADDR[1:0];

  // Next-state decode of the transfer sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (setup)  state_d = ST_ADDR;
      ST_ADDR: if (HREADY) state_d = ST_DATA;
      ST_DATA: if (HREADY) state_d = ST_DONE;
      default:             state_d = ST_IDLE;
    endcase
  end

  // State, request holding and response capture registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && setup) begin
        addr_q  <= PADDR[PADDR_WIDTH-1:2];
        write_q <= PWRITE;
        wdata_q <= PWDATA;
      end
      if (state_q == ST_DATA && HREADY) begin
        rdata_q <= HRESP ? 32'h0 : HRDATA;
        err_q   <= HRESP;
      end
    end
  end

  assign HADDR = AHB_BASE |
    {{(32-PADDR_WIDTH){1'b0}}, addr_q, 2'b00};

  assign HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ
                                          : HTRANS_IDLE;
  assign HWRITE    = write_q;
  assign HWDATA    = wdata_q;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  assign PREADY  = (state_q == ST_DONE);
  assign PSLVERR = (state_q == ST_DONE) & err_q;
  assign PRDATA  = rdata_q;

endmodule

// File: tb/tb_apb_ahb_bridge.sv
// Scoreboard bench for apb_ahb_bridge.
// Directed APB accesses against a scripted AHB slave.
module tb_apb_ahb_bridge;

  logic        HCLK;
  logic        HRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK, HWRITE;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  typedef struct {
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    int          cyc;
  } ahb_exp_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
    int          cyc;
  } apb_exp_t;

  ahb_exp_t ahb_q[$];
  apb_exp_t apb_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  apb_ahb_bridge dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Monitor: AHB address phases and APB completions
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (HTRANS == 2'b10) begin
        if (ahb_q.size() == 0) begin
          chk("ahb_unexpected_nonseq", 32'd1, 32'd0);
        end else begin
          chk("haddr", HADDR, ahb_q[0].haddr);
          chk("hwrite", {31'd0, HWRITE},
              {31'd0, ahb_q[0].hwrite});
          if (ahb_q[0].hwrite)
            chk("hwdata", HWDATA, ahb_q[0].hwdata);
          if (HREADY) begin
            chk("accept_cyc", cyc, ahb_q[0].cyc);
            void'(ahb_q.pop_front());
          end
        end
      end
      if (PREADY) begin
        if (apb_q.size() == 0) begin
          chk("apb_unexpected_pready", 32'd1, 32'd0);
        end else begin
          chk("pready_cyc", cyc, apb_q[0].cyc);
          chk("pslverr", {31'd0, PSLVERR},
              {31'd0, apb_q[0].err});
          if (apb_q[0].chk_rd)
            chk("prdata", PRDATA, apb_q[0].rd);
          void'(apb_q.pop_front());
        end
      end
    end
  end

  task automatic apb_xfer(input logic        wr,
                          input logic [15:0] a,
                          input logic [31:0] wd,
                          input int          aw,
                          input int          dw,
                          input logic [31:0] rd,
                          input logic        er,
                          input logic [31:0] exp_ha,
                          input logic [31:0] exp_rd);
    int t0;
    t0      = cyc;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = a;
    PWDATA  = wd;
    HREADY  = 1'b1;
    HRESP   = 1'b0;
    ahb_q.push_back('{haddr: exp_ha, hwrite: wr,
                      hwdata: wd, cyc: t0 + 1 + aw});
    apb_q.push_back('{rd: exp_rd, err: er, chk_rd: !wr,
                      cyc: t0 + 3 + aw + dw});
    step();
    PENABLE = 1'b1;
    repeat (aw) begin
      HREADY = 1'b0;
      step();
    end
    HREADY = 1'b1;
    step();
    repeat (dw) begin
      HREADY = 1'b0;
      HRESP  = er;
      step();
    end
    HREADY = 1'b1;
    HRESP  = er;
    HRDATA = rd;
    step();
    HRESP  = 1'b0;
    HRDATA = 32'hBAD0_BAD0;
    step();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    HRDATA  = '0;
    HREADY  = 1'b1;
    HRESP   = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("rst_haddr", HADDR, 32'h4000_0000);
    chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("hsize", {29'd0, HSIZE}, 32'd2);
    chk("hburst", {29'd0, HBURST}, 32'd0);
    chk("hprot", {28'd0, HPROT}, 32'd3);
    chk("hmastlock", {31'd0, HMASTLOCK}, 32'd0);
    HRESETn = 1'b1;
    step();

    apb_xfer(1'b1, 16'h0124, 32'hDEAD_BEEF, 0, 0,
             32'h0, 1'b0, 32'h4000_0124, 32'h0);
    apb_xfer(1'b0, 16'h0010, 32'h0, 0, 2,
             32'h1234_5678, 1'b0, 32'h4000_0010,
             32'h1234_5678);
    apb_xfer(1'b0, 16'h0020, 32'h0, 0, 1,
             32'hFFFF_FFFF, 1'b1, 32'h4000_0020,
             32'h0);
    apb_xfer(1'b1, 16'h0200, 32'h55AA_33CC, 3, 0,
             32'h0, 1'b0, 32'h4000_0200, 32'h0);
    apb_xfer(1'b1, 16'h0000, 32'h0000_0001, 0, 0,
             32'h0, 1'b0, 32'h4000_0000, 32'h0);
    apb_xfer(1'b1, 16'h0004, 32'h0000_0002, 0, 0,
             32'h0, 1'b0, 32'h4000_0004, 32'h0);
    apb_xfer(1'b1, 16'h0007, 32'h0000_0003, 0, 0,
             32'h0, 1'b0, 32'h4000_0004, 32'h0);

    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 16'h0040;
    PWDATA  = 32'hCAFE_F00D;
    ahb_q.push_back('{haddr: 32'h4000_0040, hwrite: 1'b1,
                      hwdata: 32'hCAFE_F00D, cyc: cyc + 1});
    step();
    PENABLE = 1'b1;
    HREADY  = 1'b1;
    step();
    HREADY = 1'b0;
    step();
    #1;
    HRESETn = 1'b0;
    #1;
    chk("arst_pready", {31'd0, PREADY}, 32'd0);
    chk("arst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("arst_haddr", HADDR, 32'h4000_0000);
    chk("arst_hwdata", HWDATA, 32'h0);
    chk("arst_prdata", PRDATA, 32'h0);
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    HREADY  = 1'b1;
    step();
    HRESETn = 1'b1;
    step();

    apb_xfer(1'b1, 16'h0ABC, 32'h0BAD_F00D, 0, 0,
             32'h0, 1'b0, 32'h4000_0ABC, 32'h0);
    apb_xfer(1'b0, 16'h0ABC, 32'h0, 1, 0,
             32'h0BAD_F00D, 1'b0, 32'h4000_0ABC,
             32'h0BAD_F00D);

    repeat (3) step();
    chk("ahb_q_empty", ahb_q.size(), 32'd0);
    chk("apb_q_empty", apb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
